cpu_mem_resp: RTL and testbench
===============================

CPU_MEM_RESP -- requirements
Module: cpu_mem_resp

Interface
REQ-001 Parameter WAIT_CYC, default 2: wait states inserted before each response, range 0..15.
REQ-002 Parameter DEPTH, default 256: number of 16-bit storage words, addressed by ADDR.
REQ-003 CLK  input  1: single clock; all state changes on the rising edge.
REQ-004 RST_N  input  1: reset, asynchronous and active-low.
REQ-005 REQ  input  1: CPU access request; held high until ACK.
REQ-006 WE  input  1: 1 = write, 0 = read; qualified by REQ.
REQ-007 ADDR  input  8: word address of the access.
REQ-008 WDATA  input  16: write data; qualified by REQ and WE.
REQ-009 ACK  output  1: one-cycle completion pulse.
REQ-010 RDATA  output  16: read data; valid from the ACK cycle onward.
REQ-011 BUSY  output  1: high while a transaction is in progress (WAIT or RESP state).

Function
REQ-012 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-013 In IDLE with REQ=1 at an edge, the block SHALL latch ADDR, WE and WDATA and load the wait counter with WAIT_CYC.
- Next state SHALL be WAIT, or RESP directly when WAIT_CYC=0.
REQ-014 WAIT SHALL decrement the counter each cycle and move to RESP when the counter reaches 0.
REQ-015 In RESP the block SHALL perform the access using only the latched values, assert ACK for exactly one cycle, and return to IDLE.
- Write: mem[addr] <= wdata.
- Read: RDATA <= mem[addr].
REQ-016 Latency: if REQ is sampled at edge N, ACK SHALL be high in the cycle after edge N+WAIT_CYC+1.
REQ-017 Changes on ADDR, WE or WDATA after the sampling edge SHALL have no effect on the transaction in progress.
REQ-018 REQ sampled in WAIT or RESP SHALL be ignored.
- REQ still high at the first IDLE edge after ACK SHALL start a new transaction, so back-to-back accesses are supported.
REQ-019 A write SHALL leave RDATA unchanged; RDATA SHALL hold its last read value until the next read completes.
REQ-020 Address 0xFF SHALL be valid storage; there is no address wrap and no out-of-range condition at DEPTH=256.
REQ-021 A read in RESP of an address written by the immediately preceding transaction SHALL return the new data.

Reset
REQ-022 RST_N=0 SHALL force, immediately and independent of CLK:
- state=IDLE, ACK=0, BUSY=0, RDATA=16'h0000, wait counter=0.
REQ-023 Reset asserted during WAIT or RESP SHALL abort the transaction: no ACK and no memory write.
REQ-024 Without the preload feature, memory contents SHALL NOT be affected by reset.

Configuration
REQ-025 With macro CPU_MEM_RESP_PRELOAD_EN defined, reset SHALL initialise mem[i] = {8'h00, i} for every i.
REQ-026 Without CPU_MEM_RESP_PRELOAD_EN, storage SHALL have no reset and is undefined until written.

Structure
REQ-027 Package cpu_mem_pkg SHALL hold the following; no other shared typedefs:
- FSM state encoding.
- Data width 16 and address width 8.
- Wait counter width 4.
REQ-028 Storage SHALL be one sub-module, cpu_mem_array: 256x16, synchronous write, read port registered by the parent.

Verification
REQ-029 Reset: hold RST_N=0 -> ACK=0, BUSY=0, RDATA=0x0000.
REQ-030 WAIT_CYC=2: write 0x1234 to 0x64, then read 0x64.
- ACK SHALL arrive 3 cycles after the REQ sample and be 1 cycle wide.
- The read SHALL return RDATA=0x1234.
REQ-031 WAIT_CYC=0, PRELOAD_EN: back-to-back reads of 0x00 then 0xFF with REQ held.
- ACK SHALL pulse every second cycle.
- RDATA SHALL be 0x0000, then 0x00FF.
REQ-032 PRELOAD_EN: write 0xBEEF to 0x10, then pulse RST_N low during WAIT.
- No ACK SHALL occur.
- A later read of 0x10 SHALL return 0x0010.
REQ-033 WAIT_CYC=3: read 0x20 with ADDR changed to 0x21 during WAIT -> RDATA SHALL equal mem[0x20].
REQ-034 A write of 0x5555 to 0x30 SHALL leave RDATA at the prior read value.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: bus widths, wait-counter width and FSM encoding shared by cpu_mem_resp.
package cpu_mem_pkg;
   localparam int DW = 16;
   localparam int AW = 8;
   localparam int CW = 4;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
endpackage

// File: rtl/cpu_mem_resp_if.sv
// cpu_mem_resp_if: CPU request/response bus; the CPU side is master, the responder is slave.
interface cpu_mem_resp_if;
   import cpu_mem_pkg::*;
   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          ack;
   logic [DW-1:0] rdata;
   logic          busy;
   modport master (output req, we, addr, wdata, input ack, rdata, busy);
   modport slave  (input req, we, addr, wdata, output ack, rdata, busy);
endinterface

// File: rtl/cpu_mem_array.sv
// cpu_mem_array: DEPTH x 16 storage, synchronous write, combinational read (registered by parent).
// CPU_MEM_RESP_PRELOAD_EN: reset loads mem[i] = {8'h00, i}; otherwise storage has no reset.
module cpu_mem_array
   import cpu_mem_pkg::*;
#(
   parameter int DEPTH = 256
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_wdata,
   output logic [DW-1:0] o_rdata
);
   logic [DW-1:0] r_mem [DEPTH];
`ifdef CPU_MEM_RESP_PRELOAD_EN
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n)
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= DW'(i[AW-1:0]);
      else if (i_we)
         r_mem[i_addr] <= i_wdata;
`else
   logic w_unused_rst;
   assign w_unused_rst = i_rst_n;
   always_ff @(posedge i_clk)
      if (i_we) r_mem[i_addr] <= i_wdata;
`endif
   assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/cpu_mem_resp.sv
// cpu_mem_resp: CPU memory responder inserting WAIT_CYC wait states (IDLE -> WAIT -> RESP).
// CPU_MEM_RESP_PRELOAD_EN enables reset preload of the storage array.
module cpu_mem_resp
   import cpu_mem_pkg::*;
#(
   parameter int WAIT_CYC = 2,
   parameter int DEPTH    = 256
) (
   input logic           i_clk,
   input logic           i_rst_n,
   cpu_mem_resp_if.slave bus
);
   logic [1:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic          r_we;
   logic          r_ack;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic [DW-1:0] r_rdata;
   logic [DW-1:0] w_mem_rd;
   logic          w_resp;
   assign w_resp = r_state == S_RESP;
   // the access uses only the latched request, so bus changes after sampling are ignored
   cpu_mem_array #(.DEPTH(DEPTH)) u_mem (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_we    (w_resp && r_we),
      .i_addr  (r_addr),
      .i_wdata (r_wdata),
      .o_rdata (w_mem_rd)
   );
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_ack   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_ack <= w_resp;
         if (r_state == S_IDLE) begin
            if (bus.req) begin
               r_we    <= bus.we;
               r_addr  <= bus.addr;
               r_wdata <= bus.wdata;
               r_cnt   <= CW'(WAIT_CYC);
               r_state <= (WAIT_CYC == 0) ? S_RESP : S_WAIT;
            end
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt <= CW'(1)) r_state <= S_RESP;
         end else begin
            if (!r_we) r_rdata <= w_mem_rd;
            r_state <= S_IDLE;
         end
      end
   assign bus.ack   = r_ack;
   assign bus.rdata = r_rdata;
   assign bus.busy  = r_state != S_IDLE;
endmodule

// File: tb/tb_cpu_mem_resp.sv
// tb_cpu_mem_resp: scoreboard bench over three responders (WAIT_CYC 2, 0 and 3).
module tb_cpu_mem_resp;
   localparam int W0 = 2;
   localparam int W1 = 0;
   localparam int W2 = 3;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   cpu_mem_resp_if b0 ();
   cpu_mem_resp_if b1 ();
   cpu_mem_resp_if b2 ();
   cpu_mem_resp #(.WAIT_CYC(W0)) u_d0 (.i_clk(clk), .i_rst_n(rst_n), .bus(b0));
   cpu_mem_resp #(.WAIT_CYC(W1)) u_d1 (.i_clk(clk), .i_rst_n(rst_n), .bus(b1));
   cpu_mem_resp #(.WAIT_CYC(W2)) u_d2 (.i_clk(clk), .i_rst_n(rst_n), .bus(b2));
   int n_chk = 0;
   int n_pass = 0;
   logic [15:0] m_mem [3][256];
   logic [15:0] m_rd [3];
   logic [15:0] sb [$];
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got %0h exp %0h", tag, got, exp);
   endtask
   function automatic int wc(input int k);
      return k == 0 ? W0 : k == 1 ? W1 : W2;
   endfunction
   function automatic logic get_ack(input int k);
      return k == 0 ? b0.ack : k == 1 ? b1.ack : b2.ack;
   endfunction
   function automatic logic get_busy(input int k);
      return k == 0 ? b0.busy : k == 1 ? b1.busy : b2.busy;
   endfunction
   function automatic logic [15:0] get_rd(input int k);
      return k == 0 ? b0.rdata : k == 1 ? b1.rdata : b2.rdata;
   endfunction
   task automatic drive(input int k, input logic r, input logic w, input logic [7:0] a, input logic [15:0] d);
      if (k == 0) begin b0.req = r; b0.we = w; b0.addr = a; b0.wdata = d; end
      else if (k == 1) begin b1.req = r; b1.we = w; b1.addr = a; b1.wdata = d; end
      else begin b2.req = r; b2.we = w; b2.addr = a; b2.wdata = d; end
   endtask
   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_rd[k] = 16'h0000;
`ifdef CPU_MEM_RESP_PRELOAD_EN
         for (int i = 0; i < 256; i++) m_mem[k][i] = 16'(i);
`endif
      end
   endtask
   // hold keeps REQ high for a back-to-back follow-up; chg alters ADDR/WDATA during the wait
   task automatic access(input int k, input logic we, input logic [7:0] a, input logic [15:0] d,
                         input bit hold, input bit chg);
      int n = 0;
      drive(k, 1'b1, we, a, d);
      sb.push_back(we ? m_rd[k] : m_mem[k][a]);
      if (we) m_mem[k][a] = d;
      else m_rd[k] = m_mem[k][a];
      do begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            chk("busy", 32'(get_busy(k)), 32'd1);
            if (chg) drive(k, 1'b1, we, a + 8'd1, ~d);
         end
      end while (!get_ack(k) && n < 40);
      chk("latency", n, wc(k) + 2);
      chk("rdata", 32'(get_rd(k)), 32'(sb.pop_front()));
      if (!hold) begin
         drive(k, 1'b0, 1'b0, 8'h00, 16'h0000);
         @(negedge clk);
         chk("ack_width", 32'(get_ack(k)), 32'd0);
      end
   endtask
   initial begin
      for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, 8'h00, 16'h0000);
      model_reset();
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("rst_ack", 32'(get_ack(k)), 32'd0);
         chk("rst_busy", 32'(get_busy(k)), 32'd0);
         chk("rst_rdata", 32'(get_rd(k)), 32'h0000);
      end
      rst_n = 1'b1;
      @(negedge clk);
      access(0, 1'b1, 8'h64, 16'h1234, 1'b0, 1'b0);
      access(0, 1'b0, 8'h64, 16'h0000, 1'b0, 1'b0);
      access(0, 1'b1, 8'h30, 16'h5555, 1'b0, 1'b0);
      access(0, 1'b1, 8'h10, 16'h0010, 1'b0, 1'b0);
      access(0, 1'b1, 8'hFF, 16'hA5A5, 1'b0, 1'b0);
      access(0, 1'b0, 8'hFF, 16'h0000, 1'b0, 1'b0);
      access(0, 1'b0, 8'h30, 16'h0000, 1'b0, 1'b0);
      access(1, 1'b1, 8'h00, 16'h0000, 1'b0, 1'b0);
      access(1, 1'b1, 8'hFF, 16'h00FF, 1'b0, 1'b0);
      access(1, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0);
      access(1, 1'b0, 8'hFF, 16'h0000, 1'b0, 1'b0);
      access(1, 1'b1, 8'h40, 16'hCAFE, 1'b1, 1'b0);
      access(1, 1'b0, 8'h40, 16'h0000, 1'b1, 1'b0);
      access(1, 1'b1, 8'h41, 16'h7E57, 1'b0, 1'b0);
      access(2, 1'b1, 8'h20, 16'h1111, 1'b0, 1'b0);
      access(2, 1'b1, 8'h21, 16'h2222, 1'b0, 1'b0);
      access(2, 1'b0, 8'h20, 16'h0000, 1'b0, 1'b1);
      access(2, 1'b1, 8'h23, 16'h4444, 1'b0, 1'b0);
      access(2, 1'b1, 8'h22, 16'h3333, 1'b0, 1'b1);
      access(2, 1'b0, 8'h23, 16'h0000, 1'b0, 1'b0);
      access(2, 1'b0, 8'h22, 16'h0000, 1'b0, 1'b0);
      // abort a write mid-wait: no ACK, no store, RDATA cleared
      drive(0, 1'b1, 1'b1, 8'h10, 16'hBEEF);
      @(negedge clk);
      chk("abort_busy", 32'(get_busy(0)), 32'd1);
      drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_ack", 32'(get_ack(0)), 32'd0);
      chk("abort_busy_rst", 32'(get_busy(0)), 32'd0);
      chk("abort_rdata", 32'(get_rd(0)), 32'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort_no_ack", 32'(get_ack(0)), 32'd0);
      end
      access(0, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0);
      access(0, 1'b0, 8'h64, 16'h0000, 1'b0, 1'b0);
      access(1, 1'b0, 8'h41, 16'h0000, 1'b0, 1'b0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
